// File: rtl/fibonacci_pkg.sv
// ---------------------------------------------------------------------------
// fibonacci_pkg
// Shared definitions for the Fibonacci sequence generator:
//   FIB_WIDTH    default bit width of every term / seed / fibout
//   FIB_N_WIDTH  default bit width of n and index
//   fib_state_t  generator FSM state encoding (also exported on dbg_state)
// ---------------------------------------------------------------------------
package fibonacci_pkg;

    localparam int FIB_WIDTH   = 12;
    localparam int FIB_N_WIDTH = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_OVF  = 2'd3
    } fib_state_t;

endpackage

// File: rtl/fib_ovf_adder.sv
// ---------------------------------------------------------------------------
// fib_ovf_adder
// Adds two WIDTH-bit terms at WIDTH+1 bits.
//   a, b   input  WIDTH  operands
//   sum    output WIDTH  low WIDTH bits of a+b
//   carry  output 1      carry-out; set when a+b does not fit in WIDTH bits
// ---------------------------------------------------------------------------
module fib_ovf_adder #(
    parameter int WIDTH = 12
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/fibonacci_param.sv
// ---------------------------------------------------------------------------
// fibonacci_param
// Generates a Fibonacci-style sequence from two seeds, one term per enabled
// clock, stopping either on overflow (mode 0) or after term n (mode 1).
//
// Ports
//   clk        input  1        rising-edge clock
//   rst        input  1        synchronous active-high reset
//   enb        input  1        advance enable; low freezes everything
//   start      input  1        begin a sequence (IDLE or OVF only, enb=1)
//   mode       input  1        0 = run until overflow, 1 = stop after term n
//   n          input  N_WIDTH  last term index for mode 1
//   seed0/1    input  WIDTH    first two terms
//   fibout     output WIDTH    current term
//   index      output N_WIDTH  index of current term (seed0 = 0)
//   valid      output 1        fibout/index carry a new term this cycle
//   busy       output 1        high while in RUN
//   done       output 1        one-cycle pulse when mode 1 completes
//   ovf        output 1        sticky overflow flag
//   dbg_state  output 2        current FSM state
//
// Handshake: valid is a one-way strobe with no back-pressure. Every cycle in
// which valid=1 presents exactly one new term on fibout/index; a consumer
// must capture it that cycle. valid is never high together with done.
// ---------------------------------------------------------------------------
module fibonacci_param
    import fibonacci_pkg::*;
#(
    parameter int WIDTH   = FIB_WIDTH,
    parameter int N_WIDTH = FIB_N_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enb,
    input  logic               start,
    input  logic               mode,
    input  logic [N_WIDTH-1:0] n,
    input  logic [WIDTH-1:0]   seed0,
    input  logic [WIDTH-1:0]   seed1,
    output logic [WIDTH-1:0]   fibout,
    output logic [N_WIDTH-1:0] index,
    output logic               valid,
    output logic               busy,
    output logic               done,
    output logic               ovf,
    output fib_state_t         dbg_state
);

    localparam logic [N_WIDTH-1:0] IDX_ONE = N_WIDTH'(1);

    fib_state_t         state;
    logic [WIDTH-1:0]   nxt_term;  // term that will be emitted next
    logic               nxt_bad;   // nxt_term came from a sum with carry-out
    logic               mode_r;
    logic [N_WIDTH-1:0] n_r;

    logic [WIDTH-1:0]   sum;
    logic               carry;

    // Term after nxt_term is always current + next.
    fib_ovf_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a     (fibout),
        .b     (nxt_term),
        .sum   (sum),
        .carry (carry)
    );

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            fibout   <= '0;
            index    <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            nxt_term <= '0;
            nxt_bad  <= 1'b0;
            mode_r   <= 1'b0;
            n_r      <= '0;
        end else if (!enb) begin
            // Frozen: only the new-term strobe drops.
            valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_OVF: begin
                    valid <= 1'b0;
                    if (start) begin
                        state    <= ST_RUN;
                        fibout   <= seed0;
                        index    <= '0;
                        valid    <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        ovf      <= 1'b0;
                        nxt_term <= seed1;
                        nxt_bad  <= 1'b0;
                        mode_r   <= mode;
                        n_r      <= n;
                    end
                end
                ST_RUN: begin
                    if (mode_r && (index == n_r)) begin
                        // Term n already emitted; its successor is never
                        // needed, so a pending carry does not matter here.
                        state <= ST_DONE;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (nxt_bad) begin
                        // fibout/index keep the last representable term.
                        state <= ST_OVF;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                        ovf   <= 1'b1;
                    end else begin
                        fibout   <= nxt_term;
                        index    <= index + IDX_ONE;  // wraps in mode 0
                        valid    <= 1'b1;
                        nxt_term <= sum;
                        nxt_bad  <= carry;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    valid <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fibonacci_param.sv
// ---------------------------------------------------------------------------
// tb_fibonacci_param
// Directed stimulus for fibonacci_param (WIDTH=12, N_WIDTH=6). Expected terms
// and done events are queued when each sequence is started; a negedge
// monitor pops and compares whenever the DUT shows valid or done.
// ---------------------------------------------------------------------------
module tb_fibonacci_param;
    import fibonacci_pkg::*;

    localparam int W  = 12;
    localparam int NW = 6;
    localparam int EW = 1 + NW + W;  // {is_done, index, term}

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst, enb, start, mode;
    logic [NW-1:0] n;
    logic [W-1:0]  seed0, seed1;
    logic [W-1:0]  fibout;
    logic [NW-1:0] index;
    logic          valid, busy, done, ovf;
    fib_state_t    dbg_state;

    always #5 clk = ~clk;

    fibonacci_param #(
        .WIDTH   (W),
        .N_WIDTH (NW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enb       (enb),
        .start     (start),
        .mode      (mode),
        .n         (n),
        .seed0     (seed0),
        .seed1     (seed1),
        .fibout    (fibout),
        .index     (index),
        .valid     (valid),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf),
        .dbg_state (dbg_state)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [EW-1:0] exp_q[$];

    // Hand-computed Fibonacci terms 0..18 from seeds 0,1.
    int fib_tab [19] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233,
                         377, 610, 987, 1597, 2584};

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_term(input int idx, input int term);
        exp_q.push_back({1'b0, NW'(idx), W'(term)});
    endtask

    task automatic push_done(input int idx, input int term);
        exp_q.push_back({1'b1, NW'(idx), W'(term)});
    endtask

    // Monitor: compares every presented term / done pulse with the queue.
    always @(negedge clk) begin : monitor
        logic [EW-1:0] e;
        if (valid === 1'b1 || done === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: valid=%0b done=%0b index=%0d fibout=%0d with empty queue",
                         valid, done, index, fibout);
            end else begin
                e = exp_q.pop_front();
                chk("out_kind_is_done", {31'd0, done}, {31'd0, e[EW-1]});
                chk("out_index", {26'd0, index}, {26'd0, e[W +: NW]});
                chk("out_fibout", {20'd0, fibout}, {20'd0, e[W-1:0]});
                if (done === 1'b1) chk("done_valid_low", {31'd0, valid}, 32'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int s0, input int s1, input logic m, input int nn);
        seed0 = W'(s0);
        seed1 = W'(s1);
        mode  = m;
        n     = NW'(nn);
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin
            cyc();
            k++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    // At the done cycle: check flags, then confirm the pulse lasts one cycle.
    task automatic finish_done(input string tag);
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        chk({tag, "_ovf_at_done"}, {31'd0, ovf}, 32'd0);
        cyc();
        chk({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
        chk({tag, "_back_to_idle"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; enb = 1'b0; start = 1'b0; mode = 1'b0;
        n = '0; seed0 = '0; seed1 = '0;
        repeat (3) cyc();

        // Reset state (reset wins over enb=0).
        chk("rst_fibout", {20'd0, fibout}, 32'd0);
        chk("rst_index", {26'd0, index}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;

        // start with enb=0 is ignored.
        seed0 = 12'd5; seed1 = 12'd5; start = 1'b1;
        repeat (2) cyc();
        chk("noenb_start_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("noenb_start_busy", {31'd0, busy}, 32'd0);
        start = 1'b0;
        enb   = 1'b1;

        // Mode 0 from 0,1 runs to index 18 (2584) then overflows.
        for (int i = 0; i <= 18; i++) push_term(i, fib_tab[i]);
        do_start(0, 1, 1'b0, 0);
        chk("run_busy", {31'd0, busy}, 32'd1);
        begin
            int k = 0;
            while (ovf !== 1'b1 && k < 40) begin
                cyc();
                k++;
            end
        end
        chk("ovf_set", {31'd0, ovf}, 32'd1);
        chk("ovf_valid", {31'd0, valid}, 32'd0);
        chk("ovf_fibout_hold", {20'd0, fibout}, 32'd2584);
        chk("ovf_index_hold", {26'd0, index}, 32'd18);
        chk("ovf_busy", {31'd0, busy}, 32'd0);
        chk("ovf_state", 32'(dbg_state), 32'(ST_OVF));
        repeat (2) cyc();
        chk("ovf_sticky", {31'd0, ovf}, 32'd1);
        chk("ovf_sticky_fibout", {20'd0, fibout}, 32'd2584);

        // Restart from OVF with seeds 1,1 (mode 1, n=2): 1,1,2.
        push_term(0, 1); push_term(1, 1); push_term(2, 2); push_done(2, 2);
        do_start(1, 1, 1'b1, 2);
        chk("restart_ovf_clear", {31'd0, ovf}, 32'd0);
        wait_done(10);
        finish_done("restart");

        // Mode 1 from 0,1 with n=10: last term 55.
        for (int i = 0; i <= 10; i++) push_term(i, fib_tab[i]);
        push_done(10, 55);
        do_start(0, 1, 1'b1, 10);
        wait_done(20);
        finish_done("n10");

        // Seeds 3,4, n=3: 3,4,7,11. start while in DONE is ignored.
        push_term(0, 3); push_term(1, 4); push_term(2, 7); push_term(3, 11);
        push_done(3, 11);
        do_start(3, 4, 1'b1, 3);
        wait_done(10);
        seed0 = 12'd9; seed1 = 12'd9; start = 1'b1;
        cyc();
        start = 1'b0;
        chk("start_in_done_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("start_in_done_valid", {31'd0, valid}, 32'd0);
        cyc();
        chk("start_in_done_busy", {31'd0, busy}, 32'd0);

        // n=0 emits only seed0.
        push_term(0, 5); push_done(0, 5);
        do_start(5, 9, 1'b1, 0);
        wait_done(5);
        finish_done("n0");

        // enb low for 5 cycles after term 8; resume gives 13.
        for (int i = 0; i <= 8; i++) push_term(i, fib_tab[i]);
        push_done(8, 21);
        do_start(0, 1, 1'b1, 8);
        repeat (6) cyc();
        chk("pre_pause_fibout", {20'd0, fibout}, 32'd8);
        enb = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("pause_fibout", {20'd0, fibout}, 32'd8);
            chk("pause_index", {26'd0, index}, 32'd6);
            chk("pause_valid", {31'd0, valid}, 32'd0);
            chk("pause_busy", {31'd0, busy}, 32'd1);
        end
        enb = 1'b1;
        cyc();
        chk("resume_fibout", {20'd0, fibout}, 32'd13);
        chk("resume_index", {26'd0, index}, 32'd7);
        wait_done(10);
        finish_done("pause");

        // start during RUN ignored; rst at index 7 aborts.
        for (int i = 0; i <= 7; i++) push_term(i, fib_tab[i]);
        do_start(0, 1, 1'b0, 0);
        repeat (3) cyc();
        seed0 = 12'd7; seed1 = 12'd7; mode = 1'b1; n = '0; start = 1'b1;
        cyc();
        start = 1'b0;
        chk("busy_start_index", {26'd0, index}, 32'd4);
        chk("busy_start_fibout", {20'd0, fibout}, 32'd3);
        repeat (3) cyc();
        chk("pre_rst_index", {26'd0, index}, 32'd7);
        rst = 1'b1;
        cyc();
        chk("midrst_fibout", {20'd0, fibout}, 32'd0);
        chk("midrst_index", {26'd0, index}, 32'd0);
        chk("midrst_valid", {31'd0, valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        repeat (3) cyc();
        chk("no_resume_busy", {31'd0, busy}, 32'd0);
        chk("no_resume_valid", {31'd0, valid}, 32'd0);

        // Mode 0 with zero seeds never overflows; index wraps 63 -> 0.
        for (int i = 0; i <= 64; i++) push_term(i % 64, 0);
        do_start(0, 0, 1'b0, 0);
        repeat (64) cyc();
        chk("wrap_index", {26'd0, index}, 32'd0);
        chk("wrap_valid", {31'd0, valid}, 32'd1);
        chk("wrap_busy", {31'd0, busy}, 32'd1);
        chk("wrap_no_ovf", {31'd0, ovf}, 32'd0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;

        repeat (3) cyc();
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fibonacci_param.md
FIBONACCI_PARAM -- requirements
Module: fibonacci_param

Interface
REQ-001 Parameter WIDTH, default 12: bit width of every term, seed and fibout.
REQ-002 Parameter N_WIDTH, default 6: bit width of n and index.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 enb  input  1  advance enable; when low, all state and outputs SHALL hold and valid SHALL be 0.
REQ-006 start  input  1  request to begin a sequence; accepted only in IDLE with enb=1.
REQ-007 mode  input  1  sampled at accept: 0 = run until overflow, 1 = stop after term n.
REQ-008 n  input  N_WIDTH  last term index for mode 1, sampled at accept.
REQ-009 seed0, seed1  input  WIDTH each  first two terms, sampled at accept.
REQ-010 fibout  output  WIDTH  current term.
REQ-011 index  output  N_WIDTH  index of the current term, where seed0 has index 0.
REQ-012 valid  output  1  fibout/index hold a new term this cycle.
REQ-013 busy  output  1  high in RUN.
REQ-014 done  output  1  one-cycle pulse when mode 1 completes.
REQ-015 ovf  output  1  sticky overflow flag.

Function
REQ-016 FSM states SHALL be IDLE, RUN, DONE and OVF.
REQ-017 In IDLE, start=1 and enb=1 SHALL latch the seeds, mode and n, then move to RUN.
REQ-018 The cycle after accept SHALL present fibout=seed0, index=0 and valid=1, with ovf cleared.
REQ-019 Each following RUN cycle with enb=1 SHALL emit the next term (seed1, then the sum of the previous two) with index+1 and valid=1; latency is one term per enabled cycle.
REQ-020 Each sum SHALL be computed at WIDTH+1 bits; a carry-out marks that term unrepresentable.
REQ-021 When the next term is unrepresentable: enter OVF, set ovf=1, drive valid=0, and hold fibout/index at the last valid term.
REQ-022 OVF SHALL persist until rst, or until start=1 with enb=1, which re-accepts exactly as in IDLE.
REQ-023 Mode 1: after the term with index==n is emitted, the next enabled cycle SHALL enter DONE with done=1 and valid=0, then return to IDLE.
REQ-024 Mode 1 with n=0 SHALL emit only seed0, then DONE.
REQ-025 If overflow occurs before index==n in mode 1, overflow behaviour (REQ-021) takes priority and done SHALL NOT assert.
REQ-026 In mode 0, index SHALL wrap modulo 2^N_WIDTH; wrap alone is not an error.
REQ-027 start while busy, in DONE, or with enb=0 SHALL be ignored.
REQ-028 enb=0 mid-RUN SHALL freeze the sequence; resuming SHALL continue with no term skipped or repeated.

Reset
REQ-029 rst=1 SHALL, on the next edge and with priority over enb and start, force IDLE and fibout=0, index=0, valid=0, busy=0, done=0, ovf=0, with internal term registers cleared.
REQ-030 rst asserted mid-RUN SHALL abort the sequence; a new start is required to resume.

Structure
REQ-031 Package fibonacci_pkg SHALL hold the FSM state enum and the default WIDTH/N_WIDTH constants.
REQ-032 One sub-module, fib_ovf_adder, SHALL add two WIDTH-bit terms and return the WIDTH-bit sum plus carry; everything else is in fibonacci_param.

Verification (WIDTH=12, N_WIDTH=6)
REQ-033 seeds 0,1, mode 0 -> 0,1,1,2,3,5,8,13,...; index 18 = 2584; then ovf=1 and valid=0 with fibout holding 2584.
REQ-034 seeds 0,1, mode 1, n=10 -> last valid term 55 at index 10; done pulses exactly one cycle; busy falls.
REQ-035 seeds 3,4, mode 1, n=3 -> 3,4,7,11, then done.
REQ-036 enb low for 5 cycles after term 8 -> outputs hold and valid=0; on resume next term is 13.
REQ-037 start pulsed during RUN -> ignored, sequence unchanged; rst at index 7 -> all outputs 0 next cycle, state IDLE.
REQ-038 In OVF, start with seeds 1,1 -> ovf clears; sequence 1,1,2 follows.
